// File: rtl/teller_dispatcher.sv
// teller_dispatcher: assigns queued customers to free tellers, pulses the front sensor
// line b once per departure, and tracks per-teller busy state and completed services.
// Optional build macro TELLER_MANUAL_DONE_EN: service ends on a teller_done pulse instead of a timer.
module teller_dispatcher #(
  parameter int SERVICE_CYCLES = 12,
  parameter int PULSE_W        = 2,
  parameter int GAP_CYCLES     = 3,
  parameter int SRV_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       pCount,
  input  logic [1:0]       tCount,
  input  logic [2:0]       teller_done,
  output logic             b,
  output logic             call_valid,
  output logic [1:0]       call_id,
  output logic [2:0]       teller_busy,
  output logic [SRV_W-1:0] served_count
);
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
  localparam int CMAX = PULSE_W > GAP_CYCLES ? PULSE_W : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             b_q, b_d, call_valid_q, call_valid_d;
  logic [1:0]       call_id_q, call_id_d;
  logic [2:0]       busy_q, busy_d;
  logic [SRV_W-1:0] served_q, served_d;
  logic [2:0]       open_m, free, gnt_oh, done;
  logic [1:0]       gnt, n_done;
  logic             go;
  logic [SRV_W:0]   sum;
  assign open_m = tCount == 2'd0 ? 3'b000 : tCount == 2'd1 ? 3'b001 : tCount == 2'd2 ? 3'b011 : 3'b111;
  assign free   = open_m & ~busy_q;
  assign gnt    = free[0] ? 2'd0 : free[1] ? 2'd1 : 2'd2;
  // decisions are only taken in IDLE, after the gap has let pCount settle
  assign go     = state_q == IDLE && pCount != 3'd0 && |free;
  assign gnt_oh = go ? 3'b001 << gnt : 3'b000;
`ifdef TELLER_MANUAL_DONE_EN
  localparam int unused_sc = SERVICE_CYCLES;
  // a done strobe only counts for a teller already busy, so a dispatch in the same cycle wins
  assign done = teller_done & busy_q;
`else
  localparam int TW = $clog2(SERVICE_CYCLES + 1);
  logic unused_done;
  assign unused_done = ^teller_done;
  for (genvar i = 0; i < 3; i++) begin : g_tmr
    logic [TW-1:0] tmr_q, tmr_d;
    assign done[i] = busy_q[i] && tmr_q == TW'(1);
    assign tmr_d   = gnt_oh[i] ? TW'(SERVICE_CYCLES) : busy_q[i] ? tmr_q - TW'(1) : '0;
    // per-teller service timer; loaded on dispatch, expires after SERVICE_CYCLES busy cycles
    always_ff @(posedge clk or negedge reset)
      if (!reset) tmr_q <= '0;
      else tmr_q <= tmr_d;
  end
`endif
  assign n_done   = 2'({1'b0, done[0]} + {1'b0, done[1]} + {1'b0, done[2]});
  assign sum      = {1'b0, served_q} + (SRV_W + 1)'(n_done);
  assign served_d = sum[SRV_W] ? '1 : sum[SRV_W-1:0];
  assign busy_d   = (busy_q & ~done) | gnt_oh;
  // next-state and registered outputs of the dispatch pulse/gap sequencer
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    b_d          = b_q;
    call_valid_d = 1'b0;
    call_id_d    = call_id_q;
    case (state_q)
      IDLE: if (go) begin
        state_d      = PULSE;
        cnt_d        = CW'(PULSE_W - 1);
        b_d          = 1'b1;
        call_valid_d = 1'b1;
        call_id_d    = gnt;
      end
      PULSE: if (cnt_q == '0) begin
        state_d = GAP;
        cnt_d   = CW'(GAP_CYCLES - 1);
        b_d     = 1'b0;
      end else cnt_d = cnt_q - CW'(1);
      GAP: if (cnt_q == '0) state_d = IDLE;
      else cnt_d = cnt_q - CW'(1);
      default: begin
        state_d = IDLE;
        b_d     = 1'b0;
      end
    endcase
  end
  // state and output registers; reset drops b immediately even mid-pulse
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      b_q          <= 1'b0;
      call_valid_q <= 1'b0;
      call_id_q    <= 2'd0;
      busy_q       <= 3'b000;
      served_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      b_q          <= b_d;
      call_valid_q <= call_valid_d;
      call_id_q    <= call_id_d;
      busy_q       <= busy_d;
      served_q     <= served_d;
    end
  assign b            = b_q;
  assign call_valid   = call_valid_q;
  assign call_id      = call_id_q;
  assign teller_busy  = busy_q;
  assign served_count = served_q;
endmodule
